// File: rtl/dsp_mac_sequencer.sv
// Operand-feeding controller for a DSP48E1 slice computing LEN-term dot products.
// Issues signed operand pairs, sequences OPMODE so that each vector's first
// product starts a new sum, tracks the slice pipeline with a last-term tag and
// captures the finished sum from P into a valid/ready output register. A full
// output register freezes the slice and this controller together.
module dsp_mac_sequencer #(
    parameter int unsigned LEN      = 8,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CTRL_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [24:0] s_a,
    input  logic [17:0] s_b,
    output logic [29:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [6:0]  dsp_opmode,
    output logic [3:0]  dsp_alumode,
    output logic [4:0]  dsp_inmode,
    output logic [2:0]  dsp_carryinsel,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data
);

    localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

    // X=M, Y=M, Z=0: start a new sum with the current product
    localparam logic [6:0] OPM_START = 7'b000_0101;
    // X=M, Y=M, Z=P: add the current product to the running sum
    localparam logic [6:0] OPM_ACCUM = 7'b010_0101;

    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [29:0]       a_q,       a_d;
    logic [17:0]       b_q,       b_d;
    // index 0 is the issue stage; index CTRL_DLY drives OPMODE
    logic [CTRL_DLY:0] first_q,   first_d;
    // index 0 is the issue stage; index PIPE_LAT lines up with the sum on P
    logic [PIPE_LAT:0] tag_q,     tag_d;
    logic              m_valid_q, m_valid_d;
    logic [47:0]       m_data_q,  m_data_d;

    logic tag_out;
    logic stall;
    logic accept;
    logic first;
    logic last;

    // Handshake decode, issue/shift-register next state and result capture
    always_comb begin
        tag_out   = tag_q[PIPE_LAT];
        stall     = tag_out && m_valid_q && !m_ready;
        accept    = s_valid && !stall;
        first     = (cnt_q == '0);
        last      = (cnt_q == CW'(LEN - 1));

        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        first_d   = first_q;
        tag_d     = tag_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        // While stalled everything holds, matching the frozen slice pipeline
        if (!stall) begin
            if (accept) begin
                a_d   = {{5{s_a[24]}}, s_a};
                b_d   = s_b;
                cnt_d = last ? '0 : cnt_q + CW'(1);
            end else begin
                a_d   = '0;
                b_d   = '0;
            end
            first_d[0] = accept && first;
            for (int unsigned i = 1; i <= CTRL_DLY; i++) begin
                first_d[i] = first_q[i-1];
            end
            tag_d[0] = accept && last;
            for (int unsigned i = 1; i <= PIPE_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end

        if (tag_out && (!m_valid_q || m_ready)) begin
            m_valid_d = 1'b1;
            m_data_d  = dsp_p;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers; reset discards in-flight tags and any partial count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            first_q   <= '0;
            tag_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            first_q   <= first_d;
            tag_q     <= tag_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready        = !stall;
    assign dsp_ce         = !stall;
    assign dsp_a          = a_q;
    assign dsp_b          = b_q;
    assign dsp_opmode     = first_q[CTRL_DLY] ? OPM_START : OPM_ACCUM;
    assign dsp_alumode    = '0;
    assign dsp_inmode     = '0;
    assign dsp_carryinsel = '0;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48E1 slice drives dsp_p, and a
// dot-product reference model predicts issued operands, OPMODE and results.
module tb_dsp_mac_sequencer;

    localparam int LEN      = 4;
    localparam int PIPE_LAT = 3;
    localparam int CTRL_DLY = 1;
    localparam logic [6:0] OPM_START = 7'b000_0101;
    localparam logic [6:0] OPM_ACCUM = 7'b010_0101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [24:0] s_a = '0;
    logic [17:0] s_b = '0;
    logic [29:0] dsp_a;
    logic [17:0] dsp_b;
    logic [6:0]  dsp_opmode;
    logic [3:0]  dsp_alumode;
    logic [4:0]  dsp_inmode;
    logic [2:0]  dsp_carryinsel;
    logic        dsp_ce;
    logic [47:0] dsp_p;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [47:0] m_data;

    dsp_mac_sequencer #(.LEN(LEN), .PIPE_LAT(PIPE_LAT), .CTRL_DLY(CTRL_DLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_alumode(dsp_alumode), .dsp_inmode(dsp_inmode),
        .dsp_carryinsel(dsp_carryinsel), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit timing_en = 1'b0;
    bit rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural slice: Areg=Breg=Mreg=Preg=1, registered OPMODE, one common CE.
    // Deliberately not reset, so stale P survives a sequencer reset.
    logic [29:0]        sa_r = '0;
    logic [17:0]        sb_r = '0;
    logic [6:0]         opm_r = '0;
    logic signed [47:0] m_r = '0;
    logic signed [47:0] p_r = 48'sd12345;

    always @(posedge clk) begin
        if (dsp_ce) begin
            sa_r  <= dsp_a;
            sb_r  <= dsp_b;
            opm_r <= dsp_opmode;
            m_r   <= $signed(sa_r[24:0]) * $signed(sb_r);
            p_r   <= ((opm_r[6:4] == 3'b010) ? p_r : 48'sd0) + m_r;
        end
    end
    assign dsp_p = p_r;

    // Reference model: expected issue values and an ordered queue of dot products
    typedef struct { logic [47:0] sum; int t; } res_t;
    res_t               q[$];
    logic [47:0]        got[$];
    logic [29:0]        exp_a = '0;
    logic [17:0]        exp_b = '0;
    logic [6:0]         exp_opm = OPM_ACCUM;
    bit                 exp_fi = 1'b0;
    int                 cnt_m = 0;
    logic signed [47:0] acc_m = '0;
    logic signed [24:0] ma;
    logic signed [17:0] mb;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m   = 0;
            acc_m   = '0;
            exp_a   = '0;
            exp_b   = '0;
            exp_opm = OPM_ACCUM;
            exp_fi  = 1'b0;
        end else begin
            chk("dsp_a", dsp_a, exp_a);
            chk("dsp_b", dsp_b, exp_b);
            chk("dsp_opmode", dsp_opmode, exp_opm);
            chk("const_modes", {dsp_alumode, dsp_inmode, dsp_carryinsel}, '0);
            chk("ce_eq_ready", dsp_ce, s_ready);
            if (!s_ready) chk("stall_cause", m_valid && !m_ready, 1);
            chk("spurious_valid", m_valid && (q.size() == 0), 0);
            if (m_valid && q.size() > 0) begin
                chk("m_data", m_data, q[0].sum);
                if (m_ready) begin
                    if (timing_en) chk("latency", cyc, q[0].t);
                    got.push_back(m_data);
                    void'(q.pop_front());
                end
            end
            // predict the effect of the coming edge
            if (s_ready) begin
                exp_opm = exp_fi ? OPM_START : OPM_ACCUM;
                if (s_valid) begin
                    ma     = s_a;
                    mb     = s_b;
                    exp_a  = 30'(ma);
                    exp_b  = s_b;
                    exp_fi = (cnt_m == 0);
                    acc_m  = ((cnt_m == 0) ? 48'sd0 : acc_m) + ma * mb;
                    cnt_m++;
                    if (cnt_m == LEN) begin
                        q.push_back('{acc_m, cyc + 1 + PIPE_LAT + 1});
                        cnt_m = 0;
                    end
                end else begin
                    exp_a  = '0;
                    exp_b  = '0;
                    exp_fi = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = ($urandom_range(0, 9) < 6);
    endtask

    task automatic send(input logic [24:0] a, input logic [17:0] b);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = s_ready;
            step();
        end
        chk("send_accepted", done, 1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        bit done = 1'b0;
        s_valid = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            step();
            done = (q.size() == 0) && !m_valid;
        end
        chk("drain_done", done, 1);
    endtask

    task automatic send_1234();
        send(25'd1, 18'd5); send(25'd2, 18'd6); send(25'd3, 18'd7); send(25'd4, 18'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalled;
        #3;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_dsp_a", dsp_a, 0);
        chk("rst_dsp_b", dsp_b, 0);
        chk("rst_opmode", dsp_opmode, 7'b010_0101);
        chk("rst_ce", dsp_ce, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // basic dot product, latency PIPE_LAT+1 after the last accept
        timing_en = 1'b1;
        got.delete();
        send_1234();
        drain();
        chk("t1_count", got.size(), 1);
        if (got.size() > 0) chk("t1_value", got[0], 48'd70);

        // signed operands; zero terms pad the vector to LEN
        got.delete();
        send(25'h1FFFFFD, 18'd7);
        send(25'h1000000, 18'h20000);
        send(25'd0, 18'd0);
        send(25'd0, 18'd0);
        drain();
        chk("t2_count", got.size(), 1);
        if (got.size() > 0) chk("t2_value", got[0], 48'd2199023255531);

        // two bubble cycles mid-vector
        got.delete();
        send(25'd1, 18'd5); send(25'd2, 18'd6);
        idle(2);
        send(25'd3, 18'd7); send(25'd4, 18'd8);
        drain();
        chk("t3_count", got.size(), 1);
        if (got.size() > 0) chk("t3_value", got[0], 48'd70);

        // back-to-back vectors
        got.delete();
        for (int i = 0; i < LEN; i++) send(25'd1, 18'd1);
        for (int i = 0; i < LEN; i++) send(25'd2, 18'd3);
        drain();
        chk("t4_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t4_first", got[0], 48'd4);
            chk("t4_second", got[1], 48'd24);
        end

        // backpressure across two completed vectors
        timing_en = 1'b0;
        got.delete();
        m_ready = 1'b0;
        for (int i = 0; i < LEN; i++) send(25'd1, 18'd1);
        for (int i = 0; i < LEN; i++) send(25'd2, 18'd3);
        stalled = 0;
        for (int n = 0; n < 60 && stalled == 0; n++) begin
            @(negedge clk);
            if (!s_ready) stalled = 1;
        end
        chk("t5_stall_seen", stalled, 1);
        chk("t5_ce_low", dsp_ce, 0);
        chk("t5_retained", m_data, 48'd4);
        repeat (3) step();
        chk("t5_still_stalled", s_ready, 0);
        chk("t5_still_retained", m_data, 48'd4);
        m_ready = 1'b1;
        drain();
        chk("t5_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t5_first", got[0], 48'd4);
            chk("t5_second", got[1], 48'd24);
        end

        // reset mid-vector, then a full vector
        timing_en = 1'b1;
        got.delete();
        send(25'd1, 18'd5); send(25'd2, 18'd6);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        send_1234();
        drain();
        chk("t6_count", got.size(), 1);
        if (got.size() > 0) chk("t6_value", got[0], 48'd70);

        // randomized operands, gaps and backpressure
        timing_en = 1'b0;
        got.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
            if (i % 16 == 5) send(25'h1000000, 18'h20000);
            else send(25'($urandom), 18'($urandom));
        end
        rand_rdy = 1'b0;
        m_ready = 1'b1;
        drain();
        chk("rand_count", got.size(), 75);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
